// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle RV32I datapath: fetch/decode/exec/mem/wb/trap,
// memory handshakes, store byte enables, alignment checks and memory wait timeout.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       trap_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] jumptype,
    output logic       memread,
    output logic       we,
    output logic [3:0] be,
    output logic       memtoreg,
    output logic [1:0] alusrc,
    output logic       regwrite,
    output logic [2:0] aluop,
    output logic [2:0] immtype,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_BRANCH, C_LOAD, C_STORE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_OPIMM, C_OP
    } cls_t;

    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, cls_dec;
    logic [1:0]       size_q, size_d;
    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             pc_pend_q, pc_pend_d;
    logic             to_hit;
    logic             misaligned;
    logic             unused_f3;

    assign unused_f3 = funct3[2];

    always_comb begin
        cls_dec = C_NONE;
        case (opcode)
            5'b11000: cls_dec = C_BRANCH;
            5'b00000: cls_dec = C_LOAD;
            5'b01000: cls_dec = C_STORE;
            5'b01101: cls_dec = C_LUI;
            5'b00101: cls_dec = C_AUIPC;
            5'b11011: cls_dec = C_JAL;
            5'b11001: cls_dec = C_JALR;
            5'b00100: cls_dec = C_OPIMM;
            5'b01100: cls_dec = C_OP;
            default:  cls_dec = C_NONE;
        endcase
    end

    assign to_hit = TO_EN && (cnt_q == CNT_LAST);

    // size_q holds funct3[1:0]: 00 byte, 01 half, 10 word, 11 reserved
    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            size_q    <= 2'b00;
            addr_q    <= 2'b00;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            pc_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            pc_pend_q <= pc_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        size_d    = size_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        pc_pend_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                cls_d  = cls_dec;
                size_d = funct3[1:0];
                if (cls_dec == C_NONE) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                addr_d = addr_lo;
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    if (misaligned) begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_MEM;
                    end
                end else if (cls_q == C_BRANCH) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (cls_q == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        pc_pend_d = 1'b1;
                    end
                end else if (to_hit) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: state_d = S_FETCH;
            S_TRAP: begin
                if (trap_ack) begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b0;
                    bus_err_d = 1'b0;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
            cnt_d = '0;
        end
    end

    // Store completion is seen only through dmem_ready, so its PC update lands one cycle later
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        jumptype = 2'b00;
        memread  = 1'b0;
        we       = 1'b0;
        be       = 4'b0000;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        aluop    = 3'b000;
        immtype  = 3'b111;
        alusrc   = 2'b00;
        illegal  = illegal_q;
        bus_err  = bus_err_q;
        state    = state_q;
        case (cls_q)
            C_BRANCH: begin aluop = 3'b011; immtype = 3'b100; alusrc = 2'b11; end
            C_LOAD:   begin aluop = 3'b100; immtype = 3'b001; alusrc = 2'b01; end
            C_STORE:  begin aluop = 3'b101; immtype = 3'b010; alusrc = 2'b01; end
            C_LUI:    begin aluop = 3'b000; immtype = 3'b000; alusrc = 2'b00; end
            C_AUIPC:  begin aluop = 3'b001; immtype = 3'b000; alusrc = 2'b00; end
            C_JAL:    begin aluop = 3'b010; immtype = 3'b101; alusrc = 2'b00; end
            C_JALR:   begin aluop = 3'b010; immtype = 3'b001; alusrc = 2'b00; end
            C_OPIMM:  begin aluop = 3'b110; immtype = 3'b001; alusrc = 2'b01; end
            C_OP:     begin aluop = 3'b111; immtype = 3'b111; alusrc = 2'b11; end
            default:  begin aluop = 3'b000; immtype = 3'b111; alusrc = 2'b00; end
        endcase
        case (state_q)
            S_FETCH: begin
                imem_req = !rst;
                ir_we    = imem_ready && !rst;
                pc_we    = pc_pend_q;
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    pc_we    = 1'b1;
                    jumptype = 2'b01;
                end
            end
            S_MEM: begin
                memread = (cls_q == C_LOAD);
                we      = (cls_q == C_STORE);
                if (cls_q == C_STORE) begin
                    case (size_q)
                        2'b00:   be = 4'b0001 << addr_q;
                        2'b01:   be = 4'b0011 << addr_q;
                        default: be = 4'b1111;
                    endcase
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_we    = 1'b1;
                memtoreg = (cls_q == C_LOAD);
                if (cls_q == C_JAL) begin
                    jumptype = 2'b01;
                end else if (cls_q == C_JALR) begin
                    jumptype = 2'b10;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction trace model with random waits and input noise,
// plus directed scenarios pinned by literal expectations.
module tb_multicycle_control;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [1:0] addr_lo = '0;
    logic       imem_ready = 1'b0, dmem_ready = 1'b0, trap_ack = 1'b0;
    logic       imem_req, ir_we, pc_we, memread, we, memtoreg, regwrite, illegal, bus_err;
    logic [1:0] jumptype, alusrc;
    logic [3:0] be;
    logic [2:0] aluop, immtype, state;

    multicycle_control #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .addr_lo(addr_lo),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_ack(trap_ack),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .jumptype(jumptype),
        .memread(memread), .we(we), .be(be), .memtoreg(memtoreg), .alusrc(alusrc),
        .regwrite(regwrite), .aluop(aluop), .immtype(immtype), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] jumptype;
        logic       memread;
        logic       we;
        logic [3:0] be;
        logic       memtoreg;
        logic [1:0] alusrc;
        logic       regwrite;
        logic [2:0] aluop;
        logic [2:0] immtype;
        logic       illegal;
        logic       bus_err;
        logic [2:0] state;
    } out_t;

    typedef struct {
        out_t       exp;
        logic       chk, rst, imr, dmr, ack;
        logic [4:0] op;
        logic [2:0] f3;
        logic [1:0] al;
    } ent_t;

    ent_t q[$];
    int   checks = 0, failures = 0;
    string tname = "init";

    logic [2:0] m_aluop = 3'b000, m_imm = 3'b111;
    logic [1:0] m_src = 2'b00;
    bit         m_pend = 0;

    int n_cyc, n_we, n_memread, n_rw, n_pcwe, n_imreq, rw_cyc;
    int be_or, saw_ill, saw_bus, rw_aluop, rw_src, last_imm, first_pcwe, first_state, first_we, first_imreq;

    task automatic clr_tally();
        n_cyc = 0; n_we = 0; n_memread = 0; n_rw = 0; n_pcwe = 0; n_imreq = 0; rw_cyc = -1;
        be_or = 0; saw_ill = 0; saw_bus = 0; rw_aluop = -1; rw_src = -1; last_imm = -1;
        first_pcwe = -1; first_state = -1; first_we = -1; first_imreq = -1;
    endtask

    task automatic lit(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s [%s] actual=%0d required=%0d", name, tname, act, expv);
        end
    endtask

    function automatic void class_info(input logic [4:0] op, output bit ok,
                                       output logic [2:0] a, output logic [2:0] im, output logic [1:0] s);
        ok = 1; a = 3'b000; im = 3'b111; s = 2'b00;
        case (op)
            5'b11000: begin a = 3'b011; im = 3'b100; s = 2'b11; end
            5'b00000: begin a = 3'b100; im = 3'b001; s = 2'b01; end
            5'b01000: begin a = 3'b101; im = 3'b010; s = 2'b01; end
            5'b01101: begin a = 3'b000; im = 3'b000; s = 2'b00; end
            5'b00101: begin a = 3'b001; im = 3'b000; s = 2'b00; end
            5'b11011: begin a = 3'b010; im = 3'b101; s = 2'b00; end
            5'b11001: begin a = 3'b010; im = 3'b001; s = 2'b00; end
            5'b00100: begin a = 3'b110; im = 3'b001; s = 2'b01; end
            5'b01100: begin a = 3'b111; im = 3'b111; s = 2'b11; end
            default:  ok = 0;
        endcase
    endfunction

    function automatic int access_bytes(input logic [2:0] f3);
        int sz;
        sz = 0;
        if (f3[1:0] != 2'b11) sz = 1 << f3[1:0];
        return sz;
    endfunction

    function automatic logic [3:0] bytes_touched(input logic [2:0] f3, input logic [1:0] al);
        logic [3:0] r;
        int sz, a;
        sz = access_bytes(f3);
        a = al;
        r = '0;
        for (int b = 0; b < 4; b++) r[b] = (b >= a) && (b < a + sz);
        return r;
    endfunction

    function automatic out_t base_out();
        out_t o;
        o = '0;
        o.aluop = m_aluop; o.immtype = m_imm; o.alusrc = m_src;
        return o;
    endfunction

    function automatic ent_t noise_ent(input out_t e);
        ent_t x;
        x.exp = e; x.chk = 1; x.rst = 0;
        x.imr = 1'($urandom); x.dmr = 1'($urandom); x.ack = 1'($urandom);
        x.op = 5'($urandom); x.f3 = 3'($urandom); x.al = 2'($urandom);
        return x;
    endfunction

    task automatic model_reset();
        m_aluop = 3'b000; m_imm = 3'b111; m_src = 2'b00; m_pend = 0;
    endtask

    task automatic gen_reset(input int n);
        out_t e; ent_t x;
        model_reset();
        for (int i = 0; i < n; i++) begin
            e = base_out();
            x = noise_ent(e);
            x.rst = 1; x.imr = 0; x.chk = (i != 0);
            q.push_back(x);
        end
    endtask

    task automatic gen_trap(input bit ill, input bit bus, input int ackd);
        out_t e; ent_t x;
        for (int i = 0; i <= ackd; i++) begin
            e = base_out();
            e.state = 3'd5; e.illegal = ill; e.bus_err = bus;
            x = noise_ent(e);
            x.ack = (i == ackd);
            q.push_back(x);
        end
    endtask

    // Expected trace of one instruction; wf/wm are ready wait cycles (>= T means never ready)
    task automatic gen_instr(input logic [4:0] op, input logic [2:0] f3, input logic [1:0] al,
                             input int wf, input int wm, input int ackd, input int rst_mem);
        out_t e; ent_t x; int n; bit ok; logic [2:0] a, im; logic [1:0] s;
        bit is_ld, is_st, is_br;
        n = (wf >= T) ? T : wf + 1;
        for (int i = 0; i < n; i++) begin
            e = base_out();
            e.imem_req = 1; e.pc_we = (i == 0) && m_pend; e.ir_we = (wf < T) && (i == n - 1);
            x = noise_ent(e);
            x.imr = e.ir_we;
            q.push_back(x);
        end
        m_pend = 0;
        if (wf >= T) begin gen_trap(0, 1, ackd); return; end
        e = base_out(); e.state = 3'd1;
        x = noise_ent(e); x.op = op; x.f3 = f3;
        q.push_back(x);
        class_info(op, ok, a, im, s);
        m_aluop = a; m_imm = im; m_src = s;
        if (!ok) begin gen_trap(1, 0, ackd); return; end
        is_ld = (op == 5'b00000); is_st = (op == 5'b01000); is_br = (op == 5'b11000);
        e = base_out(); e.state = 3'd2;
        if (is_br) begin e.pc_we = 1; e.jumptype = 2'b01; end
        x = noise_ent(e); x.al = al;
        q.push_back(x);
        if (is_br) return;
        if (is_ld || is_st) begin
            if (access_bytes(f3) == 0 || (int'(al) % access_bytes(f3)) != 0) begin
                gen_trap(1, 0, ackd);
                return;
            end
            n = (wm >= T) ? T : wm + 1;
            for (int i = 0; i < n; i++) begin
                e = base_out(); e.state = 3'd3;
                e.memread = is_ld; e.we = is_st;
                e.be = is_st ? bytes_touched(f3, al) : 4'b0000;
                x = noise_ent(e);
                x.dmr = (wm < T) && (i == n - 1);
                if (rst_mem == i + 1) begin
                    x.rst = 1; x.chk = 0;
                    q.push_back(x);
                    model_reset();
                    return;
                end
                q.push_back(x);
            end
            if (wm >= T) begin gen_trap(0, 1, ackd); return; end
            if (is_st) begin m_pend = 1; return; end
        end
        e = base_out(); e.state = 3'd4;
        e.regwrite = 1; e.pc_we = 1; e.memtoreg = is_ld;
        e.jumptype = (op == 5'b11011) ? 2'b01 : (op == 5'b11001) ? 2'b10 : 2'b00;
        q.push_back(x);
        q[q.size()-1] = noise_ent(e);
    endtask

    task automatic run_q();
        ent_t x; out_t act;
        while (q.size() != 0) begin
            x = q.pop_front();
            rst = x.rst; imem_ready = x.imr; dmem_ready = x.dmr; trap_ack = x.ack;
            opcode = x.op; funct3 = x.f3; addr_lo = x.al;
            #2;
            act = {imem_req, ir_we, pc_we, jumptype, memread, we, be, memtoreg, alusrc,
                   regwrite, aluop, immtype, illegal, bus_err, state};
            if (x.chk) begin
                checks++;
                n_cyc++;
                if (act !== x.exp) begin
                    failures++;
                    $display("FAIL cycle [%s] n=%0d state=%0d actual=%h required=%h",
                             tname, n_cyc, state, act, x.exp);
                end
                if (n_cyc == 1) begin
                    first_pcwe = pc_we; first_state = state; first_we = we; first_imreq = imem_req;
                end
                n_we += we; n_memread += memread; n_rw += regwrite; n_pcwe += pc_we; n_imreq += imem_req;
                if (we) be_or |= be;
                if (illegal) saw_ill = 1;
                if (bus_err) saw_bus = 1;
                if (regwrite) begin rw_cyc = n_cyc; rw_aluop = aluop; rw_src = alusrc; end
                last_imm = immtype;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [4:0] legal_ops [9] = '{5'b11000, 5'b00000, 5'b01000, 5'b01101, 5'b00101,
                                  5'b11011, 5'b11001, 5'b00100, 5'b01100};

    initial begin
        @(posedge clk);
        #1;
        tname = "reset"; clr_tally();
        gen_reset(3); run_q();
        lit("rst_immtype", last_imm, 7);
        lit("rst_imem_req", n_imreq, 0);

        tname = "alu"; clr_tally();
        gen_instr(5'b01100, 3'b000, 2'b00, 0, 0, 0, 0); run_q();
        lit("alu_first_req", first_imreq, 1);
        lit("alu_first_state", first_state, 0);
        lit("alu_cycles", n_cyc, 4);
        lit("alu_rw_cycle", rw_cyc, 4);
        lit("alu_pc_we", n_pcwe, 1);
        lit("alu_aluop", rw_aluop, 7);
        lit("alu_src", rw_src, 3);

        tname = "sh"; clr_tally();
        gen_instr(5'b01000, 3'b001, 2'b10, 0, 2, 0, 0); run_q();
        lit("sh_we_cycles", n_we, 3);
        lit("sh_be", be_or, 12);
        lit("sh_regwrite", n_rw, 0);
        lit("sh_pc_we_inside", n_pcwe, 0);
        tname = "after_sh"; clr_tally();
        gen_instr(5'b01101, 3'b000, 2'b00, 1, 0, 0, 0); run_q();
        lit("sh_pc_we_after", first_pcwe, 1);

        tname = "lw_misaligned"; clr_tally();
        gen_instr(5'b00000, 3'b010, 2'b01, 0, 0, 1, 0); run_q();
        lit("lw_mis_memread", n_memread, 0);
        lit("lw_mis_illegal", saw_ill, 1);

        tname = "load_timeout"; clr_tally();
        gen_instr(5'b00000, 3'b010, 2'b00, 0, T, 0, 0); run_q();
        lit("to_memread", n_memread, 4);
        lit("to_bus_err", saw_bus, 1);

        tname = "load_ready_last"; clr_tally();
        gen_instr(5'b00000, 3'b010, 2'b00, 0, 3, 0, 0); run_q();
        lit("last_memread", n_memread, 4);
        lit("last_bus_err", saw_bus, 0);
        lit("last_regwrite", n_rw, 1);

        tname = "fetch_timeout"; clr_tally();
        gen_instr(5'b01100, 3'b000, 2'b00, T, 0, 2, 0); run_q();
        lit("fetch_to_bus_err", saw_bus, 1);

        tname = "illegal_op"; clr_tally();
        gen_instr(5'b11111, 3'b000, 2'b00, 0, 0, 0, 0); run_q();
        lit("illegal_op", saw_ill, 1);

        tname = "mem_reset"; clr_tally();
        gen_instr(5'b01000, 3'b010, 2'b00, 0, T, 0, 2); run_q();
        lit("mem_rst_we", n_we, 1);
        tname = "after_mem_reset"; clr_tally();
        gen_instr(5'b00100, 3'b000, 2'b00, 0, 0, 0, 0); run_q();
        lit("mem_rst_state", first_state, 0);
        lit("mem_rst_we_after", first_we, 0);
        lit("mem_rst_pc_we", first_pcwe, 0);

        tname = "random";
        for (int k = 0; k < 250; k++) begin
            logic [4:0] op;
            int r, wf, wm;
            r = $urandom_range(0, 10);
            op = (r < 9) ? legal_ops[r] : 5'($urandom);
            wf = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 3);
            gen_instr(op, 3'($urandom), 2'($urandom), wf, wm, $urandom_range(0, 2),
                      ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0);
            run_q();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing control unit for the multi-cycle RV32I datapath. It replaces the single-cycle opcode decoder with a Moore state machine: FETCH, DECODE, EXEC, MEM, WB, TRAP. It drives the instruction and data memory request/ready handshakes, produces store byte enables, detects misaligned and illegal instructions, and times out stalled memory accesses. It sits between the instruction register / PC logic and the ALU, register file and memory ports.

## Interface
- `TIMEOUT`, default 16: maximum cycles a memory request may wait for ready. 0 disables the timeout.
- `CNT_W`, default 8: width of the wait counter. Must satisfy `TIMEOUT < 2**CNT_W`.
- `clk`, input, 1: the single clock; everything is sampled on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `opcode`, input, 5: instr[6:2]. Sampled in DECODE.
- `funct3`, input, 3: instr[14:12]. Sampled in DECODE.
- `addr_lo`, input, 2: ALU result [1:0]. Sampled at the end of EXEC.
- `imem_ready`, input, 1: instruction memory response strobe.
- `dmem_ready`, input, 1: data memory response strobe.
- `trap_ack`, input, 1: releases TRAP.
- `imem_req`, output, 1: instruction fetch request.
- `ir_we`, output, 1: instruction register load pulse.
- `pc_we`, output, 1: PC update pulse.
- `jumptype`, output, 2: 00 sequential, 01 PC+imm (branch or JAL), 10 rs1+imm (JALR).
- `memread`, output, 1: data memory read request.
- `we`, output, 1: data memory write request.
- `be`, output, 4: store byte enables.
- `memtoreg`, output, 1: write-back source select, 1 = memory.
- `alusrc`, output, 2: bit0 = rs1 used, bit1 = rs2 used.
- `regwrite`, output, 1: register file write pulse.
- `aluop`, output, 3: ALU operation select.
- `immtype`, output, 3: immediate format select.
- `illegal`, output, 1: illegal-opcode or misalignment trap cause.
- `bus_err`, output, 1: memory timeout trap cause.
- `state`, output, 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

## Operation
- Decode class is latched in DECODE from `opcode`; the per-class `aluop`/`immtype`/`alusrc` values hold until the next DECODE:
  - BRANCH 11000: aluop 011, imm 100, src 11.
  - LOAD 00000: aluop 100, imm 001, src 01.
  - STORE 01000: aluop 101, imm 010, src 01.
  - LUI 01101: aluop 000, imm 000, src 00.
  - AUIPC 00101: aluop 001, imm 000, src 00.
  - JAL 11011: aluop 010, imm 101, src 00.
  - JALR 11001: aluop 010, imm 001, src 00.
  - OPIMM 00100: aluop 110, imm 001, src 01.
  - OP 01100: aluop 111, imm 111, src 11.
- Any other opcode is illegal.
- FETCH:
  - `imem_req`=1 while waiting.
  - On `imem_ready`: `ir_we`=1 that cycle, then go to DECODE.
- DECODE:
  - Illegal opcode: go to TRAP with `illegal` set.
  - Otherwise go to EXEC.
- EXEC (exactly one cycle):
  - LOAD/STORE: check alignment. Halfword (funct3[1:0]=01) with `addr_lo[0]`=1 is misaligned. Word (10) with `addr_lo`≠00 is misaligned. funct3[1:0]=11 is illegal. Any of these: go to TRAP with `illegal`. Otherwise go to MEM.
  - BRANCH: `pc_we`=1, `jumptype`=01, go to FETCH.
  - All other classes: go to WB.
- MEM:
  - LOAD: `memread`=1. STORE: `we`=1.
  - `be`: byte = 0001<<addr_lo, half = 0011<<addr_lo, word = 1111. `be`=0000 for loads and outside MEM.
  - On `dmem_ready`: LOAD goes to WB; STORE pulses `pc_we` and goes to FETCH.
- WB (one cycle):
  - `regwrite`=1 and `pc_we`=1.
  - `memtoreg`=1 only for LOAD.
  - `jumptype` = 01 for JAL, 10 for JALR, else 00.
  - Go to FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments every cycle the ready input stays low.
  - When the counter equals `TIMEOUT` (and `TIMEOUT`≠0) with ready still low, drop the request and go to TRAP with `bus_err`.
  - A ready in the same cycle as the counter reaching `TIMEOUT` wins: normal completion.
- TRAP:
  - All requests and write pulses are 0.
  - `illegal`/`bus_err` hold until `trap_ack`, then both clear and go to FETCH (PC unchanged).

## Timing
- Reset:
  - With `rst`=1, the state is FETCH next cycle and the counter is 0.
  - All outputs are 0 except `immtype`=111.
  - `imem_req` is gated to 0 while `rst` is high.
  - Reset mid-MEM or mid-TRAP aborts immediately: no `we`/`regwrite` in the cycle after reset.
- All outputs are Moore: a function of registered state and latched fields only. They never depend combinationally on a ready input, except `ir_we`, which is `imem_ready` AND FETCH.
- Latency with zero-wait memory (ready high on the first request cycle):
  - OP/OPIMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- `regwrite`, `pc_we` and `ir_we` are single-cycle pulses. `pc_we` asserts at most once per instruction.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release. Expect every output 0 and `immtype`=111 during reset; `imem_req`=1 and `state`=0 in the first cycle after release.
- **ALU instruction:** opcode 01100 with `imem_ready` high in FETCH. Expect states FETCH→DECODE→EXEC→WB→FETCH and one `regwrite`+`pc_we` pulse in cycle 4, with `aluop`=111 and `alusrc`=11.
- **Halfword store:** opcode 01000, funct3 001, `addr_lo`=10, `dmem_ready` delayed 2 cycles. Expect `we`=1 and `be`=1100 for 3 cycles, then `pc_we` and no `regwrite`.
- **Misaligned word load:** opcode 00000, funct3 010, `addr_lo`=01. Expect TRAP with `illegal`=1 and no `memread`. `trap_ack` returns to FETCH.
- **Timeout:** `TIMEOUT`=4, LOAD with `dmem_ready` held low. Expect `memread` for 4 cycles, then TRAP with `bus_err`=1. Separately, ready asserted exactly on the 4th wait cycle must complete normally.
- **Illegal opcode and mid-MEM reset:** opcode 11111 goes to TRAP with `illegal` set. `rst` asserted while in MEM for a store: `we` is 0 on the next cycle and the state is FETCH.
